// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding the UART transmitter.
//   clk/rstn          clock, asynchronous active-low reset
//   wr_en/wr_data     producer push (dropped when full)
//   full/count        fill status derived from the registered entry count
//   overflow/ovf_clr  sticky dropped-push flag and its clear
//   tx_ready/tx_data  head byte presented to the transmitter
//   tx_rd             one-cycle pulse from the transmitter consuming the head byte
module uart_tx_fifo #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   output logic          full,
   output logic [AW:0]   count,
   output logic          overflow,
   input  logic          ovf_clr,
   output logic          tx_ready,
   output logic [DW-1:0] tx_data,
   input  logic          tx_rd
);
   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
   logic [DW-1:0] mem_q [2**AW];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d, push, pop;
   always_comb begin
      push     = wr_en & ~full;
      pop      = tx_rd & tx_ready;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = (push & ~pop) ? count_q + 1'b1 :
                 (pop & ~push) ? count_q - 1'b1 : count_q;
      // a dropped push sets the flag even when a clear arrives in the same cycle
      ovf_d    = (wr_en & full) | (ovf_q & ~ovf_clr);
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end
   always_comb begin
      count    = count_q;
      full     = (count_q == DEPTH);
      tx_ready = (count_q != '0);
      overflow = ovf_q;
      tx_data  = mem_q[rd_ptr_q];
   end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer that sits directly upstream of the UART transmitter. Producers (CPU store path or debug logic) push bytes at full clock rate. The FIFO presents the head byte to the transmitter through its tx_ready/tx_data/tx_rd handshake, one byte per serial frame. It also provides fill level, full status and a sticky overflow flag.

Parameters:
AW, 4, address width; depth = 2^AW entries (default 16)
DW, 8, data width; fixed to 8 for the UART path

Ports:
clk  input  1  system clock
rstn  input  1  reset, asynchronous, active-low
wr_en  input  1  push request from producer
wr_data  input  DW  byte to push
full  output  1  FIFO holds 2^AW entries
count  output  AW+1  current number of stored entries, 0..2^AW
overflow  output  1  sticky: a push was dropped because FIFO was full
ovf_clr  input  1  clears overflow
tx_ready  output  1  to transmitter: head byte valid (FIFO not empty)
tx_data  output  DW  to transmitter: head byte
tx_rd  input  1  from transmitter: one-cycle pulse, head byte consumed

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rstn low, any time, including mid-frame): rd_ptr = 0, wr_ptr = 0, count = 0, full = 0, tx_ready = 0, overflow = 0.
  - tx_data is don't-care while tx_ready = 0.
  - Storage array is not reset.
- Storage: 2^AW x DW register array. rd_ptr and wr_ptr are AW bits and wrap naturally from 2^AW-1 to 0. count is a separate AW+1-bit register.
- Status, all derived from registered count:
  - tx_ready = (count != 0)
  - full = (count == 2^AW)
- tx_data = mem[rd_ptr], combinational read. It is stable while tx_ready is high until the cycle after a pop.
- Push accepted at a clock edge when wr_en = 1 and full = 1'b0 (status as seen before the edge):
  - mem[wr_ptr] <= wr_data; wr_ptr increments.
  - A push arriving while full is dropped, even if a pop occurs in the same cycle.
- Pop accepted at a clock edge when tx_rd = 1 and count != 0: rd_ptr increments.
  - tx_rd while empty is ignored. No pointer or count change.
- count update per edge:
  - +1 on accepted push only
  - -1 on accepted pop only
  - unchanged on both or neither
- Latency:
  - Push into an empty FIFO: tx_ready high and tx_data = pushed byte in the cycle after the push edge.
  - After a pop, the next head byte is presented in the following cycle.
- Transmitter handshake:
  - The transmitter samples tx_data on the edge where it sees tx_ready = 1 while idle.
  - It pulses tx_rd for one cycle on the next cycle.
  - The FIFO must not advance rd_ptr before tx_rd, so the sampled byte is never skipped or repeated.
  - tx_ready remaining high between the capture and tx_rd is legal; the transmitter is busy and ignores it.
- overflow:
  - Set on any edge with wr_en = 1 and full = 1.
  - Cleared on an edge with ovf_clr = 1.
  - If set and clear occur in the same cycle, set wins.
- Bytes leave in strict push order. There is no data loss except drops that are flagged by overflow.

Test Plan:
- Reset then idle → tx_ready = 0, full = 0, count = 0, overflow = 0. Release rstn, push 0x41 → next cycle tx_ready = 1, tx_data = 0x41, count = 1. Pulse tx_rd → next cycle tx_ready = 0, count = 0.
- Push 0x00..0x0F back to back (16 cycles) → full = 1, count = 16. A 17th push of 0xAA → dropped, overflow = 1. Then pop 16 times → tx_data sequence is 0x00..0x0F, and 0xAA never appears.
- Connect to the UART transmitter (DIV_CNT = 867) and push "Hi\n" (0x48, 0x69, 0x0A) in 3 consecutive cycles → serial line carries exactly three 10-bit frames in that order. Exactly one tx_rd pulse per frame; count ends at 0.
- Wrap-around: push and pop 20 bytes with at most 3 outstanding → pointers wrap past 15. Output order is preserved and count never exceeds 3.
- Simultaneous events:
  - With count = 5, assert wr_en and tx_rd in the same cycle → count stays 5 and head advances.
  - With full = 1, wr_en and tx_rd together → count becomes 15 and overflow = 1.
  - ovf_clr together with a dropped push → overflow stays 1.
- Assert rstn low mid-operation with count = 7 → count = 0 and tx_ready = 0 immediately, without waiting for a clock edge. tx_rd while empty → no change, count stays 0.
